// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, RMW sub-word stores, extended loads, WAIT_CYCLES stalls.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t       state;
  state_t       state_next;
  logic         we_q;
  logic [2:0]   f3_q;
  logic [AW+1:0] addr_q;
  logic [31:0]  wdata_q;
  logic [31:0]  old_q;
  logic [3:0]   cnt;
  logic         cnt_done;
  logic         req_illegal;
  logic [31:0]  mem [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0]  mem_word;
  logic [31:0]  shifted;
  logic [7:0]   byte_v;
  logic [15:0]  half_v;
  logic [31:0]  load_data;
  logic [31:0]  merged;
  logic         unused_addr;

  assign idx         = addr_q[AW+1:2];
  assign mem_word    = mem[idx];
  assign cnt_done    = (cnt == 4'd0);
  assign unused_addr = ^req_addr[31:AW+2];

  // Classify the incoming request before it is accepted
  always_comb begin
    req_illegal = 1'b0;
    if (req_we)
      req_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    else
      req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((req_funct3[1:0] == 2'b01) && req_addr[0])
      req_illegal = 1'b1;
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
      req_illegal = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_illegal)
            state_next = RESP;
          else if (req_we && (req_funct3 == 3'b010))
            state_next = WR;
          else
            state_next = RD;
        end
      end
      RD:      if (cnt_done) state_next = we_q ? WR : RESP;
      WR:      if (cnt_done) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    resp_valid = (state == RESP);
  end

  // Load path: pick the addressed lane and extend it according to funct3
  always_comb begin
    shifted   = mem_word >> {addr_q[1:0], 3'b000};
    byte_v    = shifted[7:0];
    half_v    = addr_q[1] ? mem_word[31:16] : mem_word[15:0];
    load_data = 32'd0;
    case (f3_q)
      3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_data = {{16{half_v[15]}}, half_v};
      3'b010:  load_data = mem_word;
      3'b100:  load_data = {24'd0, byte_v};
      3'b101:  load_data = {16'd0, half_v};
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    merged = old_q;
    case (f3_q[1:0])
      2'b00: begin
        case (addr_q[1:0])
          2'b00:   merged[7:0]   = wdata_q[7:0];
          2'b01:   merged[15:8]  = wdata_q[7:0];
          2'b10:   merged[23:16] = wdata_q[7:0];
          default: merged[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1])
          merged[31:16] = wdata_q[15:0];
        else
          merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  // Write only on the last WR edge; a coincident reset suppresses it
  always_ff @(posedge clk) begin
    if (reset && (state == WR) && cnt_done)
      mem[idx] <= merged;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            f3_q       <= req_funct3;
            addr_q     <= req_addr[AW+1:0];
            wdata_q    <= req_wdata;
            cnt        <= 4'(WAIT_CYCLES);
            resp_err   <= req_illegal;
            resp_rdata <= 32'd0;
          end
        end
        RD: begin
          if (cnt_done) begin
            cnt <= 4'(WAIT_CYCLES);
            if (we_q)
              old_q <= mem_word;
            else
              resp_rdata <= load_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WR: begin
          if (!cnt_done)
            cnt <= cnt - 4'd1;
        end
        RESP: begin
          if (resp_ready) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
          end
        end
        default: cnt <= 4'd0;
      endcase
    end
  end

endmodule
